// File: rtl/apb_regfile.sv
// APB4 completer with a small bank of byte-strobed read/write registers.
// Define APB_REGFILE_WAIT_STATES_EN to insert WAIT_CYCLES wait states per transfer.
module apb_regfile #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int unsigned IW = ADDR_WIDTH - 2;
    localparam int unsigned NB = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [IW-1:0]         paddr_idx;
    logic                  paddr_err;
    logic                  setup;
    logic                  ready;
    logic                  done;
    logic                  cnt_zero;
    logic [DATA_WIDTH-1:0] rd_word;

    assign paddr_idx = PADDR[ADDR_WIDTH-1:2];
    assign paddr_err = (PADDR[1:0] != 2'b00) || (32'(paddr_idx) >= NUM_REGS);

    assign setup = PSEL && !PENABLE;
    assign ready = (state_q == ACCESS) && cnt_zero;
    assign done  = PSEL && PENABLE && ready;

`ifdef APB_REGFILE_WAIT_STATES_EN
    logic [3:0] cnt_q, cnt_d;

    assign cnt_zero = (cnt_q == 4'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (setup) begin
                cnt_d = 4'(WAIT_CYCLES);
            end
        end else if (!PSEL) begin
            cnt_d = 4'd0;
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the counter every access phase is ready immediately.
    localparam int unsigned W_EFF = WAIT_CYCLES & 0;

    assign cnt_zero = (W_EFF == 0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    idx_d   = paddr_idx;
                    write_d = PWRITE;
                    err_d   = paddr_err;
                end
            end
            ACCESS: begin
                if (!PSEL || done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (done && write_q && !err_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IW'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (PSTRB[b]) begin
                            regs_d[i][8*b +: 8] = PWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IW'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign PREADY  = ready;
    assign PSLVERR = ready && err_q;
    assign PRDATA  = (ready && !write_q && !err_q) ? rd_word : '0;

endmodule

// File: doc/apb_regfile.md
# apb_regfile

APB4 completer holding a small bank of word-wide read/write registers, clocked by `PCLK`. It is the design-under-test stage that the property modules bind to. It consumes APB transfers from the bus requester, inserts a fixed number of wait states, and flags erroneous accesses with `PSLVERR`.

## Interface
Parameters:
- `ADDR_WIDTH`, 8 — width of `PADDR`.
- `DATA_WIDTH`, 32 — width of `PWDATA`/`PRDATA`; must be 32.
- `NUM_REGS`, 8 — number of registers, 1..2^(ADDR_WIDTH-2).
- `WAIT_CYCLES`, 2 — wait states inserted per transfer, 0..15; only used with `APB_REGFILE_WAIT_STATES_EN`.

Ports:
- `PCLK`  in  1  — clock; all logic on its rising edge.
- `PRESETn`  in  1  — reset, synchronous, active-low.
- `PSEL`  in  1  — completer select.
- `PENABLE`  in  1  — access phase indicator.
- `PWRITE`  in  1  — 1 = write, 0 = read.
- `PADDR`  in  ADDR_WIDTH  — byte address.
- `PWDATA`  in  DATA_WIDTH  — write data.
- `PSTRB`  in  DATA_WIDTH/8  — write byte-lane enables.
- `PRDATA`  out  DATA_WIDTH  — read data.
- `PREADY`  out  1  — transfer completes this cycle.
- `PSLVERR`  out  1  — transfer error; valid only while `PREADY`=1.

## Operation
- The register index is `PADDR[ADDR_WIDTH-1:2]`.
- An access is an error when `PADDR[1:0]`≠0 or when index ≥ `NUM_REGS`.
- The FSM has two states, IDLE and ACCESS. Reset enters IDLE.
- IDLE → ACCESS when `PSEL`=1 and `PENABLE`=0 (setup phase).
  - On that edge the block latches the index, `PWRITE`, and the error flag.
  - It loads the wait counter with `WAIT_CYCLES`.
- In ACCESS:
  - Counter ≠0: `PREADY`=0, and the counter decrements each cycle.
  - Counter =0: `PREADY`=1.
  - `PREADY` is decoded from the registered state and counter only; it has no combinational path from the inputs.
- Completion happens on the edge where `PSEL`&`PENABLE`&`PREADY`. The FSM then returns to IDLE.
  - Write, no error: each byte lane with `PSTRB[i]`=1 takes `PWDATA[8i+7:8i]`. Other lanes hold.
  - Read, no error: `PRDATA` = register[index] while `PREADY`=1. Otherwise `PRDATA`=0.
  - Error: `PSLVERR`=1 while `PREADY`=1, no register changes, and `PRDATA`=0.
- `PSTRB` is ignored on reads.
- `PSEL` dropping in ACCESS before completion aborts the transfer: next state IDLE, no write, no error.
- Back-to-back transfers: a setup phase in the cycle after a completion is accepted normally, with no idle cycle required.
- Reset asserted mid-transfer aborts the transfer: all registers, the counter and the FSM are cleared on that edge.

## Timing
- Reset values: all registers 0, `PRDATA`=0, `PREADY`=0, `PSLVERR`=0, FSM IDLE, counter 0.
- With W = effective wait states, a transfer occupies 2+W cycles: 1 setup cycle + W wait cycles + 1 completing cycle.
- Write data is visible to a read whose setup phase starts in the cycle after the write completes.
- `PREADY`, `PSLVERR` and `PRDATA` are all 0 in IDLE.

## Configuration
- `APB_REGFILE_WAIT_STATES_EN` defined:
  - The wait counter (4 bits) is compiled in.
  - W = `WAIT_CYCLES`.
- Not defined:
  - No counter is instantiated and `WAIT_CYCLES` is ignored.
  - W = 0, so `PREADY`=1 in the first ACCESS cycle and every transfer takes 2 cycles.
  - All other behaviour is identical.

## Test plan
- Reset then read at `PADDR`=0x04 → `PRDATA`=0x00000000, `PSLVERR`=0.
- Write 0xDEADBEEF to 0x08 with `PSTRB`=0xF, then read 0x08 → 0xDEADBEEF.
  - With the macro and `WAIT_CYCLES`=2, `PREADY` rises in the 4th cycle of each transfer.
- Write 0x11223344 to 0x0C with `PSTRB`=0x5 over prior 0xFFFFFFFF → read returns 0xFF22FF44.
- Write to 0x20 (index 8 ≥ `NUM_REGS`) and to 0x02 (misaligned) → `PSLVERR`=1 on the completing cycle; a subsequent read of 0x00 returns its unchanged value.
- Drop `PSEL` during the first wait cycle of a write to 0x00 → no register change, FSM back in IDLE, `PREADY` stays 0.
  - The next setup phase is accepted immediately.
- Assert `PRESETn`=0 during the ACCESS phase of a write to 0x04 holding 0xA5A5A5A5 → after reset, a read of 0x04 returns 0, and `PREADY`/`PSLVERR` are 0 through reset.
